// File: rtl/fnd_pkg.sv
// fnd_pkg: shared digit geometry, digit-enable patterns and blanking helper for the FND scanner.
package fnd_pkg;
   localparam int NUM_DIGIT = 4;
   localparam int NIBBLE_W = 4;
   localparam logic [NUM_DIGIT-1:0] DIG_N [NUM_DIGIT] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   localparam logic [NUM_DIGIT-1:0] DIG_OFF = 4'b1111;
   localparam logic [NUM_DIGIT-1:0] RST_EN = 4'b1110;
   // True when digit k and every higher digit are zero; digit0 is never blanked.
   function automatic logic lz_blank(input logic [NUM_DIGIT*NIBBLE_W-1:0] d, input logic [1:0] k);
      return k != 2'd0 && (d >> {k, 2'b00}) == '0;
   endfunction
endpackage

// File: rtl/fnd_tick.sv
// fnd_tick: digit-slot prescaler, counts 0..CLK_DIV-1 and pulses o_tick on the last count.
module fnd_tick #(
   parameter int CLK_DIV = 50000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_tick
);
   localparam int CW = $clog2(CLK_DIV);
   logic [CW-1:0] cnt;
   assign o_tick = cnt == CW'(CLK_DIV - 1);
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) cnt <= '0;
      else cnt <= o_tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/fnd_scan.sv
// fnd_scan: 4-digit multiplexed display scanner with a one-word pending buffer swapped in on frame wrap.
// Leading-zero blanking is compiled in with the FND_LZB_EN macro.
module fnd_scan
   import fnd_pkg::*;
#(
   parameter int CLK_DIV = 50000,
   parameter int DW = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   input  logic [DW-1:0]        i_data,
   output logic                 o_ready,
   output logic [NIBBLE_W-1:0]  o_nibble,
   output logic [NUM_DIGIT-1:0] o_digit_n
);
   logic tick, wrap, full, take;
   logic [1:0] idx, idx_nx;
   logic [DW-1:0] disp, disp_nx, pend;
   logic [NUM_DIGIT-1:0] en_nx;
   fnd_tick #(.CLK_DIV(CLK_DIV)) u_tick (.i_clk(i_clk), .i_rst_n(i_rst_n), .o_tick(tick));
   assign wrap = tick && idx == 2'd3;
   assign take = i_valid && !full;
   assign o_ready = !full;
   assign idx_nx = tick ? idx + 2'd1 : idx;
   // Pending is only promoted if it was already full before this wrap, so a word taken now waits a frame.
   assign disp_nx = (wrap && full) ? pend : disp;
`ifdef FND_LZB_EN
   assign en_nx = lz_blank(disp_nx, idx_nx) ? DIG_OFF : DIG_N[idx_nx];
`else
   assign en_nx = DIG_N[idx_nx];
`endif
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         idx <= '0;
         disp <= '0;
         pend <= '0;
         full <= 1'b0;
         o_nibble <= '0;
         o_digit_n <= RST_EN;
      end else begin
         idx <= idx_nx;
         disp <= disp_nx;
         if (take) pend <= i_data;
         full <= take || (full && !wrap);
         o_nibble <= disp_nx[{idx_nx, 2'b00} +: NIBBLE_W];
         o_digit_n <= en_nx;
      end
endmodule

// File: doc/fnd_scan.md
FND_SCAN -- requirements
Module: fnd_scan

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 50000, giving the number of clocks per digit slot (legal range 2..65535).
REQ-002 The block SHALL have parameter DW, default 16, giving the display word width (fixed at 4 digits x 4 bits).
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port i_valid, input, 1 bit: new display word offered.
REQ-006 The block SHALL have port i_data, input, 16 bits: hex word, digit3 = [15:12] ... digit0 = [3:0].
REQ-007 The block SHALL have port o_ready, output, 1 bit: pending buffer empty, so i_data can be accepted.
REQ-008 The block SHALL have port o_nibble, output, 4 bits: hex value of the active digit, fed to the segment decoder.
REQ-009 The block SHALL have port o_digit_n, output, 4 bits: active-low digit enables, at most one bit low.

Function
REQ-010 A prescaler SHALL count 0..CLK_DIV-1 and wrap to 0; tick SHALL be asserted on the count CLK_DIV-1.
REQ-011 The digit index SHALL advance 0->1->2->3->0 on each tick; frame_wrap = tick AND index==3.
REQ-012 A transfer SHALL occur when i_valid and o_ready are both 1; i_data SHALL then be stored in the pending register, and o_ready SHALL go to 0 on the next clock.
REQ-013 On frame_wrap with pending full, pending SHALL move to the display register, and o_ready SHALL return to 1 on the next clock.
REQ-014 A word accepted in the same cycle as frame_wrap SHALL be displayed from the following frame_wrap, never the current one, so that no frame is torn.
REQ-015 While o_ready is 0, i_valid SHALL be ignored; the source SHALL hold i_valid and i_data until the transfer.
REQ-016 o_nibble SHALL be display[4*idx+3 : 4*idx], and o_digit_n SHALL be ~(1<<idx); both SHALL be registered, so the outputs update 1 clock after the tick.
REQ-017 Each digit slot SHALL last exactly CLK_DIV clocks, and a full frame SHALL last 4*CLK_DIV clocks.

Reset
REQ-018 While i_rst_n is 0, the block SHALL immediately hold: prescaler=0, idx=0, display=0x0000, pending empty, o_ready=1, o_nibble=0x0, o_digit_n=4'b1110.
REQ-019 A reset mid-frame or with pending full SHALL discard the pending word; scanning SHALL restart at digit0 on the first clock after release.

Configuration
REQ-020 The block SHALL provide leading-zero blanking, compiled in by the macro FND_LZB_EN.
REQ-021 With FND_LZB_EN defined, a slot for digit k (k=3..1) SHALL drive o_digit_n=4'b1111 when nibble k and all higher nibbles are 0; digit0 SHALL never be blanked, and o_nibble SHALL still carry the value.
REQ-022 Without FND_LZB_EN, all four digits SHALL always be enabled in their slot.

Structure
REQ-023 Shared package fnd_pkg SHALL hold: NUM_DIGIT=4, NIBBLE_W=4, the digit-enable one-hot-low constants, and the reset enable value 4'b1110.
REQ-024 The prescaler SHALL be a sub-module fnd_tick (parameter CLK_DIV; ports i_clk, i_rst_n, o_tick); the scan/handshake logic SHALL stay in fnd_scan.
REQ-025 The segment decode SHALL stay outside this block, downstream of o_nibble.

Verification (CLK_DIV=4)
REQ-026 Bench SHALL check reset: hold i_rst_n=0 -> o_digit_n=1110, o_nibble=0, o_ready=1; release -> digit enables rotate every 4 clocks.
REQ-027 Bench SHALL check load: offer 0x1234 -> after the next frame_wrap, slots show o_nibble 4,3,2,1 with o_digit_n 1110,1101,1011,0111, 4 clocks each.
REQ-028 Bench SHALL check back-pressure: offer 0xAAAA then hold 0x5555 -> o_ready=0 until 1 clock after frame_wrap; 0x5555 is accepted afterwards and shown one frame after 0xAAAA.
REQ-029 Bench SHALL check a simultaneous event: offer 0xBEEF exactly on a frame_wrap cycle with pending empty -> the current frame still shows the old word; 0xBEEF appears from the next frame_wrap.
REQ-030 Bench SHALL check blanking: with FND_LZB_EN, 0x0050 -> digit3,2 slots o_digit_n=1111, digit1 shows 5, digit0 shows 0; 0x0000 -> only digit0 enabled; without the macro, all digits enabled.
REQ-031 Bench SHALL check reset mid-operation: assert i_rst_n=0 at digit2 with pending full -> outputs return to reset values asynchronously; after release, display=0x0000 and the pending word is lost.
